// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory_unit command port arbiter: func codes,
// bus widths, FSM state encodings and the per-requester command record.
package memory_arbiter_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        GET_CONTENTS = 2'd0,
        SET_CONTENTS = 2'd1,
        GET_FREE     = 2'd2
    } mem_func_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [1:0]            func;
        logic [MEM_ADDR_W-1:0] addr1;
        logic [MEM_ADDR_W-1:0] addr2;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/memory_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module mem_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] sel,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IW'(j);
                sel[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin sequencer sharing the single memory_unit command port between
// N_REQ requesters; one command in flight, aborted after TIMEOUT WAIT cycles.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [2*N_REQ-1:0]          req_func,
    input  logic [MEM_ADDR_W*N_REQ-1:0] req_addr1,
    input  logic [MEM_ADDR_W*N_REQ-1:0] req_addr2,
    input  logic [MEM_DATA_W*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            done,
    output logic                        err,
    output logic [MEM_DATA_W-1:0]       rdata1,
    output logic [MEM_DATA_W-1:0]       rdata2,
    output logic [MEM_ADDR_W-1:0]       free_addr_out,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [1:0]                  mem_func,
    output logic                        mem_execute,
    output logic [MEM_ADDR_W-1:0]       mem_addr1,
    output logic [MEM_ADDR_W-1:0]       mem_addr2,
    output logic [MEM_DATA_W-1:0]       mem_wdata,
    input  logic                        mem_is_ready,
    input  logic [MEM_DATA_W-1:0]       mem_read_data1,
    input  logic [MEM_DATA_W-1:0]       mem_read_data2,
    input  logic [MEM_ADDR_W-1:0]       mem_free_addr
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e       state, next_state;
    logic [IW-1:0]    ptr, gidx, pick_idx;
    logic [N_REQ-1:0] pick_sel;
    logic             pick_any, start, cnt_hit, timed_out;
    logic [CNT_W-1:0] cnt;
    mem_cmd_t         cmd [N_REQ];
    mem_cmd_t         cur;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign cmd[i] = '{func:  req_func[2*i +: 2],
                          addr1: req_addr1[MEM_ADDR_W*i +: MEM_ADDR_W],
                          addr2: req_addr2[MEM_ADDR_W*i +: MEM_ADDR_W],
                          wdata: req_wdata[MEM_DATA_W*i +: MEM_DATA_W]};
    end

    mem_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr),
        .sel (pick_sel),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign start   = pick_any & mem_is_ready;
    assign cnt_hit = (cnt == CNT_W'(TIMEOUT));

    assign mem_func  = cur.func;
    assign mem_addr1 = cur.addr1;
    assign mem_addr2 = cur.addr2;
    assign mem_wdata = cur.wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ARB_IDLE;
        else      state <= next_state;
    end

    // mem_is_ready is ignored in ISSUE: the memory unit holds it low under execute.
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:  if (start) next_state = ARB_ISSUE;
            ARB_ISSUE: next_state = ARB_WAIT;
            ARB_WAIT:  if (mem_is_ready || cnt_hit) next_state = ARB_DONE;
            ARB_DONE:  next_state = ARB_IDLE;
            default:   next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_execute = (state == ARB_ISSUE);
        busy        = (state != ARB_IDLE);
        done        = (state == ARB_DONE) ? grant : '0;
        err         = (state == ARB_DONE) && timed_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr           <= '0;
            gidx          <= '0;
            grant         <= '0;
            cur           <= '0;
            cnt           <= '0;
            timed_out     <= 1'b0;
            timeout_err   <= 1'b0;
            rdata1        <= '0;
            rdata2        <= '0;
            free_addr_out <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (start) begin
                    grant <= pick_sel;
                    gidx  <= pick_idx;
                    cur   <= cmd[pick_idx];
                end
                ARB_ISSUE: begin
                    cnt       <= '0;
                    timed_out <= 1'b0;
                end
                ARB_WAIT: begin
                    if (mem_is_ready) begin
                        if (cur.func == GET_CONTENTS) begin
                            rdata1 <= mem_read_data1;
                            rdata2 <= mem_read_data2;
                        end else if (cur.func == GET_FREE) begin
                            free_addr_out <= mem_free_addr;
                        end
                    end else if (cnt_hit) begin
                        timed_out   <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB_DONE: begin
                    grant <= '0;
                    ptr   <= (gidx == IW'(N_REQ-1)) ? '0 : gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Round-robin arbiter and sequencer that shares the single `memory_unit` command port between `N_REQ` independent requesters (e.g. traversal engine, opcode executor, noun builder). It serialises their GET_CONTENTS / SET_CONTENTS / GET_FREE commands and drives the memory unit's execute/is_ready handshake. It returns read data and allocated addresses to the granted requester and flags commands that never complete, such as a GET_FREE that falls into garbage collection. It sits between the requesters and `memory_unit`; no requester drives `memory_unit` directly.

## Interface
- `N_REQ`, 3: number of requesters, 2..8.
- `TIMEOUT`, 1023: max cycles in WAIT before abort, 1..65535.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: per-requester request level.
- `req_func` in 2*N_REQ: packed func codes (`GET_CONTENTS`/`SET_CONTENTS`/`GET_FREE` from `memory_unit.vh`), slice i = [2i+1:2i].
- `req_addr1`, `req_addr2` in `memory_addr_width`*N_REQ: packed addresses.
- `req_wdata` in `memory_data_width`*N_REQ: packed write data / GET_FREE length.
- `grant` out N_REQ: one-hot; requester owning the port, high from ISSUE through DONE.
- `done` out N_REQ: one-hot, one-cycle completion pulse.
- `err` out 1: high with `done` when the command timed out.
- `rdata1`, `rdata2` out `memory_data_width`: captured read data, held until next capture.
- `free_addr_out` out `memory_addr_width`: captured free address, held.
- `busy` out 1: FSM not in IDLE.
- `timeout_err` out 1: sticky, set on any timeout, cleared only by reset.
- `mem_func` out 2, `mem_execute` out 1, `mem_addr1`/`mem_addr2` out `memory_addr_width`, `mem_wdata` out `memory_data_width`: to memory unit.
- `mem_is_ready` in 1, `mem_read_data1`/`mem_read_data2` in `memory_data_width`, `mem_free_addr` in `memory_addr_width`: from memory unit.

## Operation
- Reset values: all outputs 0, state IDLE, priority pointer 0, timeout counter 0.
- FSM states:
  - **IDLE**: if `mem_is_ready` and any `req`, pick the first requester at or after the pointer (wrapping mod N_REQ). Latch its func/addr/wdata into the `mem_*` registers, set `grant`, go to ISSUE. Otherwise stay.
  - **ISSUE**: `mem_execute`=1 for exactly this cycle. Go to WAIT and clear the counter.
  - **WAIT**: `mem_execute`=0 and operands held stable.
    - If `mem_is_ready`: latch `mem_read_data1/2` into `rdata1/2` (GET_CONTENTS only) or `mem_free_addr` into `free_addr_out` (GET_FREE only), then go to DONE.
    - Else if the counter equals TIMEOUT: set `timeout_err`, go to DONE with `err` pending.
    - Else increment the counter.
  - **DONE**: pulse `done[g]`, plus `err` if timed out. Set pointer = (g+1) mod N_REQ, clear `grant`, go to IDLE.
- Requesters hold `req` and their operands stable from assertion until they see `done`. They drop `req` by the next edge unless issuing a new command.
- A requester whose `req` drops before `grant` is simply not selected; there is no abort once granted.
- `mem_is_ready` is ignored in ISSUE, because the memory unit forces it low while execute is high.
- SET_CONTENTS leaves `rdata*`/`free_addr_out` unchanged.
- After a timeout, `memory_unit` state is undefined. The arbiter keeps arbitrating, but further commands stall until `mem_is_ready` returns (which requires a system reset).
- Reset mid-operation: everything returns to reset values immediately. No `done` is generated for the in-flight command.

## Timing
- Request sampled in IDLE at cycle t → `mem_execute` at t+1 → `done` at R+1, where R is the first WAIT cycle with `mem_is_ready`=1.
- Against `memory_unit`:
  - GET_CONTENTS: R=t+4, `done` t+5.
  - SET_CONTENTS: R=t+4, `done` t+5.
  - GET_FREE (no GC): R=t+3, `done` t+4.
- `rdata*`/`free_addr_out` are valid in the `done` cycle and held afterwards.
- Back-to-back: next IDLE arbitration at `done`+1, so the earliest re-issue is `done`+2.
- Timeout: `done`+`err` at t+TIMEOUT+3.

## Structure
- `memory_unit.vh` keeps the func codes and width macros. Add `ARB_IDLE/ISSUE/WAIT/DONE` state encodings (2 bits) there for shared waveform decoding.
- Sub-module `mem_rr_pick`: combinational round-robin picker, inputs `req` and pointer, outputs one-hot selection and index.
- The arbiter instantiates `mem_rr_pick` and muxes the packed operand buses by index.

## Test plan
- Reset with `mem_is_ready`=0 for 6 cycles and req[0]=1: no `mem_execute` until ready. After ready: one GET_CONTENTS with addr1=5, addr2=6; `rdata1/2` equal mem[5]/mem[6] at `done[0]`, 5 cycles after sampling.
- req[0..2] all held continuously with SET_CONTENTS to addresses 10/11/12: `grant` order 0,1,2,0; `mem_execute` is exactly one cycle per command; memory contents verified afterwards.
- req[2] GET_FREE with wdata=4 while free pointer = 100: `free_addr_out`=100 at `done[2]`, 4 cycles after sampling. A second GET_FREE returns 104.
- Memory model never raises ready, TIMEOUT=20: `done[g]`+`err` at t+23 and `timeout_err` sticky high. Later requests are never issued.
- Async `rst` low during WAIT: all outputs 0 within the reset cycle, no `done`. After release, pointer 0 and the req[1]-only request is serviced normally.
- req[1] drops before grant while req[2] is high: `grant[2]` is issued and requester 1 is never serviced.
